debounce_bank: RTL and testbench

Multi-channel, parametrised push-button conditioner: every channel gets a two-flop synchroniser, a restartable stability counter and registered edge pulses. It sits between the board switches/buttons and the CPU control logic (single-step, run/stop, display select). It replaces per-button debounce instances with one bank that reports clean levels plus one-cycle press/release strobes.

---
 rtl/debounce_bank.sv | 115 +++++++++++
 tb/tb_debounce_bank.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/debounce_bank.sv
// Multi-channel push-button conditioner: 2-flop synchroniser, restartable stability
// counter and registered press/release strobes per channel. Optional auto-repeat: DEBOUNCE_AUTOREPEAT_EN.
module debounce_bank #(
    parameter int unsigned CHANNELS      = 5,
    parameter int unsigned LIMIT         = 100_000,
    parameter logic        RESET_LEVEL   = 1'b0,
    parameter int unsigned REPEAT_DELAY  = 2_500_000,
    parameter int unsigned REPEAT_PERIOD = 500_000
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic [CHANNELS-1:0] button,
    output logic [CHANNELS-1:0] button_s,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall
);

    localparam int unsigned CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;
    localparam int unsigned RW = (REPEAT_DELAY > 0) ? $clog2(REPEAT_DELAY + 1) : 1;

    if (CHANNELS < 1) begin : g_chk_channels
        $error("debounce_bank: CHANNELS must be at least 1");
    end
    if (LIMIT < 2) begin : g_chk_limit
        $error("debounce_bank: LIMIT must be at least 2");
    end
    if (REPEAT_PERIOD < 1 || REPEAT_PERIOD > REPEAT_DELAY) begin : g_chk_repeat
        $error("debounce_bank: need 1 <= REPEAT_PERIOD <= REPEAT_DELAY");
    end

    typedef enum logic {
        S_IDLE,
        S_COUNT
    } state_e;

    state_e              state_q [CHANNELS];
    logic [CW-1:0]       count_q [CHANNELS];
    logic [CHANNELS-1:0] sync1_q;
    logic [CHANNELS-1:0] sync2_q;
    logic [CHANNELS-1:0] level_q;
    logic [CHANNELS-1:0] rise_q;
    logic [CHANNELS-1:0] fall_q;
`ifdef DEBOUNCE_AUTOREPEAT_EN
    logic [RW-1:0]       rpt_q   [CHANNELS];
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= {CHANNELS{RESET_LEVEL}};
            sync2_q <= {CHANNELS{RESET_LEVEL}};
            level_q <= {CHANNELS{RESET_LEVEL}};
            rise_q  <= '0;
            fall_q  <= '0;
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                state_q[i] <= S_IDLE;
                count_q[i] <= '0;
`ifdef DEBOUNCE_AUTOREPEAT_EN
                rpt_q[i]   <= '0;
`endif
            end
        end else begin
            sync1_q <= button;
            sync2_q <= sync1_q;
            rise_q  <= '0;
            fall_q  <= '0;
            for (int unsigned i = 0; i < CHANNELS; i++) begin
`ifdef DEBOUNCE_AUTOREPEAT_EN
                // Reload keeps later strobes REPEAT_PERIOD apart; a commit below overrides this.
                if (level_q[i]) begin
                    if (rpt_q[i] == RW'(REPEAT_DELAY - 1)) begin
                        rpt_q[i]  <= RW'(REPEAT_DELAY - REPEAT_PERIOD);
                        rise_q[i] <= 1'b1;
                    end else begin
                        rpt_q[i] <= rpt_q[i] + RW'(1);
                    end
                end
`endif
                case (state_q[i])
                    S_IDLE: begin
                        count_q[i] <= '0;
                        if (sync2_q[i] != level_q[i]) begin
                            state_q[i] <= S_COUNT;
                        end
                    end
                    S_COUNT: begin
                        if (sync2_q[i] == level_q[i]) begin
                            state_q[i] <= S_IDLE;
                            count_q[i] <= '0;
                        end else if (count_q[i] == CW'(LIMIT - 1)) begin
                            level_q[i] <= sync2_q[i];
                            rise_q[i]  <= sync2_q[i];
                            fall_q[i]  <= ~sync2_q[i];
                            state_q[i] <= S_IDLE;
                            count_q[i] <= '0;
`ifdef DEBOUNCE_AUTOREPEAT_EN
                            rpt_q[i]   <= '0;
`endif
                        end else begin
                            count_q[i] <= count_q[i] + CW'(1);
                        end
                    end
                    default: begin
                        state_q[i] <= S_IDLE;
                        count_q[i] <= '0;
                    end
                endcase
            end
        end
    end

    assign button_s = level_q;
    assign rise     = rise_q;
    assign fall     = fall_q;

endmodule

// File: tb/tb_debounce_bank.sv
// Directed and randomized bench for debounce_bank (2 channels, LIMIT=4) against a
// run-length reference model of the acceptance and auto-repeat rules.
module tb_debounce_bank;

    localparam int CH = 2;
    localparam int LIM = 4;
    localparam int RD = 10;
    localparam int RP = 4;

    logic          clock;
    logic          reset_n;
    logic [CH-1:0] button;
    logic [CH-1:0] button_s;
    logic [CH-1:0] rise;
    logic [CH-1:0] fall;

    int n_cmp;
    int n_fail;

    logic [CH-1:0] m_lvl, m_rise, m_fall, m_d1, m_d2;
    int            m_run  [CH];
    int            m_held [CH];

    debounce_bank #(
        .CHANNELS(CH),
        .LIMIT(LIM),
        .RESET_LEVEL(1'b0),
        .REPEAT_DELAY(RD),
        .REPEAT_PERIOD(RP)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .button(button),
        .button_s(button_s),
        .rise(rise),
        .fall(fall)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish by 200000, required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m_lvl  = '0;
        m_rise = '0;
        m_fall = '0;
        m_d1   = '0;
        m_d2   = '0;
        for (int c = 0; c < CH; c++) begin
            m_run[c]  = 0;
            m_held[c] = 0;
        end
    endfunction

    // A change is accepted once LIM+1 consecutive edges see the twice-delayed input
    // differ from the current level; any agreeing edge restarts the run.
    function automatic void model_edge();
        if (!reset_n) return;
        for (int c = 0; c < CH; c++) begin
            logic s, old, r, f;
            s = m_d2[c];
            old = m_lvl[c];
            r = 1'b0;
            f = 1'b0;
            if (s != old) begin
                m_run[c]++;
                if (m_run[c] == LIM + 1) begin
                    m_lvl[c] = s;
                    m_run[c] = 0;
                    r = s;
                    f = !s;
                end
            end else begin
                m_run[c] = 0;
            end
`ifdef DEBOUNCE_AUTOREPEAT_EN
            if (old && !f) begin
                m_held[c]++;
                if (m_held[c] >= RD && (m_held[c] - RD) % RP == 0) r = 1'b1;
            end
            if ((r && !old) || f) m_held[c] = 0;
`endif
            m_rise[c] = r;
            m_fall[c] = f;
        end
        m_d2 = m_d1;
        m_d1 = button;
    endfunction

    task automatic tick();
        @(posedge clock);
        model_edge();
        #1;
        check("button_s", 32'(button_s), 32'(m_lvl));
        check("rise", 32'(rise), 32'(m_rise));
        check("fall", 32'(fall), 32'(m_fall));
    endtask

    task automatic do_reset(input int cycles);
        reset_n = 1'b0;
        model_reset();
        #1;
        check("async_reset", 32'({rise, fall, button_s}), 32'd0);
        for (int i = 0; i < cycles; i++) tick();
        reset_n = 1'b1;
    endtask

    initial begin
        int            found;
        logic          seen;
        logic [CH-1:0] strobes;
        logic [31:0]   mask;
        logic [31:0]   exp_mask;

        n_cmp   = 0;
        n_fail  = 0;
        reset_n = 1'b0;
        button  = '0;
        model_reset();

        // Reset held while inputs toggle
        for (int i = 0; i < 8; i++) begin
            tick();
            button = ~button;
        end
        check("reset_hold_outputs", 32'({rise, fall, button_s}), 32'd0);
        button  = '0;
        reset_n = 1'b1;
        repeat (4) tick();

        // Reset while channel 0 is mid-count, then release with input at reset level
        button = 2'b01;
        repeat (4) tick();
        button = '0;
        do_reset(2);
        strobes = '0;
        for (int i = 0; i < 10; i++) begin
            tick();
            strobes |= rise | fall;
        end
        check("reset_release_quiet", 32'(strobes), 32'd0);
        check("reset_release_level", 32'(button_s), 32'd0);

        // Clean press on channel 0
        button = 2'b01;
        found = -1;
        for (int k = 0; k < 16; k++) begin
            tick();
            if (button_s[0]) begin
                found = k;
                check("press_strobe", 32'({rise, fall}), 32'b0100);
                check("press_ch1_level", 32'(button_s[1]), 32'd0);
                break;
            end
        end
        check("press_latency", 32'(found), 32'd6);

        // Release right after the press
        button = 2'b00;
        found = -1;
        seen = 1'b0;
        for (int k = 0; k < 16; k++) begin
            tick();
            seen |= rise[0];
            if (fall[0]) begin
                found = k;
                break;
            end
        end
        check("release_latency", 32'(found), 32'd6);
        check("release_no_rise", 32'(seen), 32'd0);
        check("release_level", 32'(button_s[0]), 32'd0);

        // Bounce: 3 high / 1 low repeated must never commit
        seen = 1'b0;
        for (int r = 0; r < 4; r++) begin
            button = 2'b01;
            repeat (3) begin
                tick();
                seen |= button_s[0] | rise[0];
            end
            button = 2'b00;
            tick();
            seen |= button_s[0] | rise[0];
        end
        check("bounce_no_commit", 32'(seen), 32'd0);
        button = 2'b01;
        found = -1;
        for (int k = 0; k < 16; k++) begin
            tick();
            if (rise[0]) begin
                found = k;
                break;
            end
        end
        check("bounce_steady_latency", 32'(found), 32'd6);

        // Move to ch0 low / ch1 high, then swap both in the same cycle
        button = 2'b10;
        found = -1;
        for (int k = 0; k < 16; k++) begin
            tick();
            if (button_s == 2'b10) begin
                found = k;
                break;
            end
        end
        check("swap_setup_latency", 32'(found), 32'd6);
        button = 2'b01;
        found = -1;
        for (int k = 0; k < 16; k++) begin
            tick();
            if (rise[0] || fall[1]) begin
                found = k;
                check("opposite_strobes", 32'({rise, fall}), 32'b0110);
                break;
            end
        end
        check("opposite_latency", 32'(found), 32'd6);

        // Auto-repeat pattern for a long press on channel 0
        button = 2'b00;
        repeat (10) tick();
        button = 2'b01;
        found = -1;
        mask = '0;
        for (int k = 0; k < 16; k++) begin
            tick();
            if (button_s[0]) begin
                found = k;
                mask[0] = rise[0];
                break;
            end
        end
        check("repeat_press_latency", 32'(found), 32'd6);
        for (int off = 1; off <= 30; off++) begin
            tick();
            mask[off] = rise[0];
        end
        exp_mask = 32'd1;
`ifdef DEBOUNCE_AUTOREPEAT_EN
        for (int off = RD; off <= 30; off += RP) exp_mask[off] = 1'b1;
`endif
        check("repeat_pattern", mask, exp_mask);
        button = 2'b00;
        repeat (10) tick();

        // Randomized segments with occasional asynchronous resets
        for (int seg = 0; seg < 70; seg++) begin
            button = 2'($urandom);
            if ($urandom_range(0, 19) == 0) do_reset(int'($urandom_range(1, 3)));
            repeat ($urandom_range(1, 14)) tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
